// File: rtl/uart_pkg.sv
// Shared types and helpers for the extended UART receiver.
// Holds the FSM state encoding, parity mode codes and small combinational helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5,
    WAIT_IDLE = 3'd6
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // px is the XOR of the data bits and the received parity bit
  function automatic logic parity_err(input int mode, input logic px);
    case (mode)
      PARITY_ODD:  return ~px;
      PARITY_EVEN: return px;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Resets to 1 so an idle-high line does not look active out of reset.
module sync_2ff (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // metastability filter: two back-to-back flops
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_ext.sv
// Configurable UART receiver: majority-voted sampling, parity/framing checks and
// break detection. One o_rx_dv pulse per frame; data and flags hold until the next.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_rx_uart,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CW  = clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] C_MIDM1 = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID   = CW'(MID);
  localparam logic [CW-1:0] C_MIDP1 = CW'(MID + 1);
  localparam logic [CW-1:0] C_MIDP2 = CW'(MID + 2);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    C_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    C_LAST_STOP = 4'(STOP_BITS - 1);

  logic w_rx_s;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_bit_idx, w_idx_nxt;
  logic r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shadow;
  logic r_par_bit;
  logic r_stop_err;
  logic r_rx_dv, r_parity_err, r_frame_err, r_break, r_busy;
  logic [DATA_BITS-1:0] r_rx_byte;

  logic w_vote, w_at_vote, w_end, w_commit, w_break, w_px;

  sync_2ff u_sync (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_async  (i_rx_uart),
    .o_sync   (w_rx_s)
  );

  assign w_vote    = maj3(r_s0, r_s1, w_rx_s);
  assign w_at_vote = (r_cnt == C_MIDP1);
  assign w_end     = (r_cnt == C_LAST);
  assign w_commit  = (w_state_nxt == DONE);
  assign w_px      = (^r_shadow) ^ r_par_bit;
  assign w_break   = r_stop_err & ~(|r_shadow) &
                     ((PARITY_MODE == PARITY_NONE) | ~r_par_bit);

  // next-state, bit counter and cycle counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_bit_idx;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = 4'd0;
        if (!w_rx_s) w_state_nxt = START;
        else         w_state_nxt = IDLE;
      end
      START: begin
        if (w_at_vote && w_vote) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_end) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == C_LAST_DATA) begin
            w_idx_nxt   = 4'd0;
            w_state_nxt = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
          end else begin
            w_idx_nxt = r_bit_idx + 4'd1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      PARITY: begin
        if (w_end) begin
          w_state_nxt = STOP;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = PARITY;
        end
      end
      STOP: begin
        // last stop bit commits early so a new start bit can follow immediately
        if ((r_bit_idx == C_LAST_STOP) && (r_cnt == C_MIDP2)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 4'd0;
        end else if (w_end) begin
          w_cnt_nxt = '0;
          w_idx_nxt = r_bit_idx + 4'd1;
        end else begin
          w_state_nxt = STOP;
        end
      end
      DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = r_break ? WAIT_IDLE : IDLE;
      end
      WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
        else        w_state_nxt = WAIT_IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  // state, sampling, shadow capture and registered outputs
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 4'd0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_shadow     <= '0;
      r_par_bit    <= 1'b0;
      r_stop_err   <= 1'b0;
      r_rx_dv      <= 1'b0;
      r_rx_byte    <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_break      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_rx_dv   <= w_commit;
      if (r_cnt == C_MIDM1) r_s0 <= w_rx_s;
      if (r_cnt == C_MID)   r_s1 <= w_rx_s;
      if (r_state == START) begin
        r_stop_err <= 1'b0;
      end else if (w_at_vote && (r_state == DATA)) begin
        // shifting in from the top leaves the first wire bit at the LSB
        r_shadow <= {w_vote, r_shadow[DATA_BITS-1:1]};
      end else if (w_at_vote && (r_state == PARITY)) begin
        r_par_bit <= w_vote;
      end else if (w_at_vote && (r_state == STOP) && !w_vote) begin
        r_stop_err <= 1'b1;
      end
      if (w_commit) begin
        r_rx_byte    <= r_shadow;
        r_parity_err <= parity_err(PARITY_MODE, w_px);
        r_frame_err  <= r_stop_err;
        r_break      <= w_break;
      end
    end
  end

  assign o_rx_dv      = r_rx_dv;
  assign o_rx_byte    = r_rx_byte;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_break      = r_break;
  assign o_busy       = r_busy;

endmodule
